// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus-side controller.
package z80_bus_pkg;

    localparam int unsigned MAX_WAIT = 15;
    // I/O port that loads the IM2 vector register (used only with Z80_IM2_VEC_EN).
    localparam logic [7:0]  VEC_PORT = 8'hFF;

    typedef enum logic [1:0] {WtIdle, WtCount, WtHold, WtDone} wait_st_t;
    typedef enum logic [1:0] {ArbIdle, ArbReq, ArbGnt, ArbRel} arb_st_t;
    typedef enum logic [1:0] {CycNone, CycMem, CycIo, CycInta} cyc_t;

    // Classify the current bus cycle from the CPU status pins; refresh is never a mem cycle.
    function automatic cyc_t cyc_decode(input logic m1_n, input logic mreq_n,
                                        input logic iorq_n, input logic rfsh_n);
        cyc_t c;
        c = CycNone;
        if (!iorq_n && !m1_n) begin
            c = CycInta;
        end else if (!iorq_n) begin
            c = CycIo;
        end else if (!mreq_n && rfsh_n) begin
            c = CycMem;
        end
        return c;
    endfunction

endpackage

// File: rtl/z80_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, returned one-hot and as an index.
module z80_rr_arbiter #(
    parameter int unsigned NCH = 2,
    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [PW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [PW-1:0]  idx_o
);

    function automatic logic [PW-1:0] wrap(input int unsigned v);
        return PW'(v % NCH);
    endfunction

    logic found;

    // Scan requests starting at the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!found && req_i[wrap(32'(ptr_i) + k)]) begin
                found = 1'b1;
                idx_o = wrap(32'(ptr_i) + k);
            end
        end
        if (found) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 bus-side controller: wait-state generation, INT/NMI conditioning, DMA bus arbitration.
// Optional feature: define Z80_IM2_VEC_EN to add the IM2 vector register and drive enable.
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned NCH      = 2,
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 1,
    parameter int unsigned INT_LEN  = 32,
    parameter int unsigned NMI_LEN  = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clken_i,
    input  logic           m1_ni,
    input  logic           mreq_ni,
    input  logic           iorq_ni,
    input  logic           rd_ni,
    input  logic           wr_ni,
    input  logic           rfsh_ni,
    input  logic           busak_ni,
    input  logic [AW-1:0]  a_i,
    input  logic           ext_rdy_i,
    input  logic           int_req_i,
    input  logic           nmi_req_i,
    input  logic [NCH-1:0] dma_req_i,
    output logic           wait_no,
    output logic           int_no,
    output logic           nmi_no,
    output logic           busrq_no,
    output logic [NCH-1:0] dma_gnt_o,
    output logic [7:0]     vec_do_o,
    output logic           vec_oe_o
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IW = $clog2(INT_LEN + 1);
    localparam int unsigned NW = $clog2(NMI_LEN + 1);

    if (MEM_WAIT > MAX_WAIT || IO_WAIT > MAX_WAIT) begin : g_wait_range
        $error("wait-state count exceeds the 4-bit counter");
    end
    if (NCH < 1 || NCH > 8) begin : g_nch_range
        $error("NCH must be 1..8");
    end
    if (NMI_LEN < 1) begin : g_nmi_range
        $error("NMI_LEN must be at least 1");
    end

    cyc_t cyc;
    assign cyc = cyc_decode(m1_ni, mreq_ni, iorq_ni, rfsh_ni);

    // ---------------- wait-state generator ----------------
    wait_st_t   wt_q, wt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] wt_load;
    logic       strobes_idle;

    assign strobes_idle = mreq_ni & iorq_ni & rd_ni & wr_ni;

    // Wait FSM state and countdown register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wt_q  <= WtIdle;
            cnt_q <= '0;
        end else begin
            wt_q  <= wt_d;
            cnt_q <= cnt_d;
        end
    end

    // Wait FSM next state; only advances on a T-state.
    always_comb begin
        wt_d    = wt_q;
        cnt_d   = cnt_q;
        wt_load = '0;
        case (cyc)
            CycMem:  wt_load = 4'(MEM_WAIT);
            CycIo:   wt_load = 4'(IO_WAIT);
            default: wt_load = '0;
        endcase
        if (clken_i) begin
            unique case (wt_q)
                WtIdle: begin
                    if (cyc != CycNone) begin
                        cnt_d = wt_load;
                        if (wt_load != 4'd0) begin
                            wt_d = WtCount;
                        end else begin
                            wt_d = ext_rdy_i ? WtDone : WtHold;
                        end
                    end
                end
                WtCount: begin
                    if (cyc == CycNone) begin
                        wt_d = WtIdle;
                    end else if (cnt_q <= 4'd1) begin
                        wt_d = ext_rdy_i ? WtDone : WtHold;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                WtHold: begin
                    if (cyc == CycNone) begin
                        wt_d = WtIdle;
                    end else if (ext_rdy_i) begin
                        wt_d = WtDone;
                    end
                end
                WtDone: begin
                    if (strobes_idle) begin
                        wt_d = WtIdle;
                    end
                end
            endcase
        end
    end

    assign wait_no = !((wt_q == WtCount) || (wt_q == WtHold));

    // ---------------- INT / NMI conditioning ----------------
    logic [1:0]    int_s_q, nmi_s_q;
    logic          int_p_q, nmi_p_q;
    logic          int_edge, nmi_edge;
    logic          int_act_q, int_act_d, nmi_act_q, nmi_act_d;
    logic [IW-1:0] int_cnt_q, int_cnt_d;
    logic [NW-1:0] nmi_cnt_q, nmi_cnt_d;

    assign int_edge = int_s_q[1] & ~int_p_q;
    assign nmi_edge = nmi_s_q[1] & ~nmi_p_q;

    // Two-flop synchronisers plus previous-value flops for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_s_q <= '0;
            nmi_s_q <= '0;
            int_p_q <= 1'b0;
            nmi_p_q <= 1'b0;
        end else begin
            int_s_q <= {int_s_q[0], int_req_i};
            nmi_s_q <= {nmi_s_q[0], nmi_req_i};
            int_p_q <= int_s_q[1];
            nmi_p_q <= nmi_s_q[1];
        end
    end

    // Pulse state and T-state countdowns for INT and NMI.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_act_q <= 1'b0;
            int_cnt_q <= '0;
            nmi_act_q <= 1'b0;
            nmi_cnt_q <= '0;
        end else begin
            int_act_q <= int_act_d;
            int_cnt_q <= int_cnt_d;
            nmi_act_q <= nmi_act_d;
            nmi_cnt_q <= nmi_cnt_d;
        end
    end

    // Edges arriving while a pulse is already active are dropped.
    always_comb begin
        int_act_d = int_act_q;
        int_cnt_d = int_cnt_q;
        if (!int_act_q) begin
            if (int_edge) begin
                int_act_d = 1'b1;
                int_cnt_d = IW'(INT_LEN);
            end
        end else if (cyc == CycInta) begin
            int_act_d = 1'b0;
            int_cnt_d = '0;
        end else if (clken_i) begin
            if (int_cnt_q <= IW'(1)) begin
                int_act_d = 1'b0;
                int_cnt_d = '0;
            end else begin
                int_cnt_d = int_cnt_q - IW'(1);
            end
        end

        nmi_act_d = nmi_act_q;
        nmi_cnt_d = nmi_cnt_q;
        if (!nmi_act_q) begin
            if (nmi_edge) begin
                nmi_act_d = 1'b1;
                nmi_cnt_d = NW'(NMI_LEN);
            end
        end else if (clken_i) begin
            if (nmi_cnt_q <= NW'(1)) begin
                nmi_act_d = 1'b0;
                nmi_cnt_d = '0;
            end else begin
                nmi_cnt_d = nmi_cnt_q - NW'(1);
            end
        end
    end

    assign int_no = ~int_act_q;
    assign nmi_no = ~nmi_act_q;

    // ---------------- DMA bus arbiter ----------------
    arb_st_t        arb_q, arb_d;
    logic [NCH-1:0] gnt_q, gnt_d, rr_gnt;
    logic [PW-1:0]  ptr_q, ptr_d, idx_q, idx_d, rr_idx;

    z80_rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .req_i (dma_req_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
    );

    // Arbiter FSM, grant and round-robin pointer registers; runs on every clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_q <= ArbIdle;
            gnt_q <= '0;
            ptr_q <= '0;
            idx_q <= '0;
        end else begin
            arb_q <= arb_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            idx_q <= idx_d;
        end
    end

    // One grant per BUSAK episode; the pointer moves past the channel just served.
    always_comb begin
        arb_d = arb_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        idx_d = idx_q;
        unique case (arb_q)
            ArbIdle: begin
                if (|dma_req_i) begin
                    arb_d = ArbReq;
                end
            end
            ArbReq: begin
                if (!(|dma_req_i)) begin
                    arb_d = ArbRel;
                end else if (!busak_ni) begin
                    gnt_d = rr_gnt;
                    idx_d = rr_idx;
                    arb_d = ArbGnt;
                end
            end
            ArbGnt: begin
                if (!(|(dma_req_i & gnt_q))) begin
                    gnt_d = '0;
                    ptr_d = PW'((32'(idx_q) + 32'd1) % NCH);
                    arb_d = ArbRel;
                end
            end
            ArbRel: begin
                if (busak_ni) begin
                    arb_d = ArbIdle;
                end
            end
        endcase
    end

    assign busrq_no  = !((arb_q == ArbReq) || (arb_q == ArbGnt));
    // Never present a grant while the CPU still owns the bus.
    assign dma_gnt_o = gnt_q & {NCH{~busak_ni}};

    // ---------------- IM2 vector ----------------
`ifdef Z80_IM2_VEC_EN
    logic [7:0] vec_q;

    // Vector byte loaded from the upper address byte on an OUT to VEC_PORT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vec_q <= 8'hFF;
        end else if ((cyc == CycIo) && !wr_ni && (a_i[7:0] == VEC_PORT)) begin
            vec_q <= a_i[AW-1 -: 8];
        end
    end

    assign vec_do_o = vec_q;
    assign vec_oe_o = (cyc == CycInta);
`else
    logic unused_a;
    assign unused_a = ^a_i;
    assign vec_do_o = 8'hFF;
    assign vec_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Scoreboard bench for z80_bus_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_z80_bus_ctrl;

    localparam int unsigned NCH = 2;

    localparam int SigWait  = 0;
    localparam int SigInt   = 1;
    localparam int SigNmi   = 2;
    localparam int SigBusrq = 3;
    localparam int SigGnt   = 4;
    localparam int SigVecOe = 5;
    localparam int SigVecDo = 6;

`ifdef Z80_IM2_VEC_EN
    localparam logic [7:0] InTaOe = 8'd1;
`else
    localparam logic [7:0] InTaOe = 8'd0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clken = 1'b0;
    logic           m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
    logic           rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1, busak_n = 1'b1;
    logic [15:0]    a = 16'h0000;
    logic           ext_rdy = 1'b1, int_req = 1'b0, nmi_req = 1'b0;
    logic [NCH-1:0] dma_req = '0;
    logic           wait_n, int_n, nmi_n, busrq_n, vec_oe;
    logic [NCH-1:0] dma_gnt;
    logic [7:0]     vec_do;

    z80_bus_ctrl #(
        .AW       (16),
        .NCH      (NCH),
        .MEM_WAIT (2),
        .IO_WAIT  (1),
        .INT_LEN  (32),
        .NMI_LEN  (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clken_i   (clken),
        .m1_ni     (m1_n),
        .mreq_ni   (mreq_n),
        .iorq_ni   (iorq_n),
        .rd_ni     (rd_n),
        .wr_ni     (wr_n),
        .rfsh_ni   (rfsh_n),
        .busak_ni  (busak_n),
        .a_i       (a),
        .ext_rdy_i (ext_rdy),
        .int_req_i (int_req),
        .nmi_req_i (nmi_req),
        .dma_req_i (dma_req),
        .wait_no   (wait_n),
        .int_no    (int_n),
        .nmi_no    (nmi_n),
        .busrq_no  (busrq_n),
        .dma_gnt_o (dma_gnt),
        .vec_do_o  (vec_do),
        .vec_oe_o  (vec_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [7:0] sample(input int sig);
        case (sig)
            SigWait:  return {7'd0, wait_n};
            SigInt:   return {7'd0, int_n};
            SigNmi:   return {7'd0, nmi_n};
            SigBusrq: return {7'd0, busrq_n};
            SigGnt:   return {6'd0, dma_gnt};
            SigVecOe: return {7'd0, vec_oe};
            default:  return vec_do;
        endcase
    endfunction

    task automatic chk(input int sig, input logic [7:0] val, input string name);
        exp_t e;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: drain every pending expectation at the falling edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = sample(e.sig);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
            end
        end
    end

    // One T-state: a clock with CLKEN high followed by one with CLKEN low.
    task automatic tick();
        clken = 1'b1;
        @(posedge clk);
        #1 clken = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_int();
        int_req = 1'b1;
        idle(2);
        int_req = 1'b0;
        idle(3);
    endtask

    task automatic pulse_nmi();
        nmi_req = 1'b1;
        idle(2);
        nmi_req = 1'b0;
        idle(3);
    endtask

    // Let the monitor consume queued checks, then align to just after a rising edge.
    task automatic settle();
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(SigWait,  8'd1,  {tag, " wait"});
        chk(SigInt,   8'd1,  {tag, " int"});
        chk(SigNmi,   8'd1,  {tag, " nmi"});
        chk(SigBusrq, 8'd1,  {tag, " busrq"});
        chk(SigGnt,   8'd0,  {tag, " gnt"});
        chk(SigVecOe, 8'd0,  {tag, " vec_oe"});
        chk(SigVecDo, 8'hFF, {tag, " vec_do"});
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        chk_reset_outputs("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Memory read, MEM_WAIT=2, slave ready.
        mreq_n = 1'b0; rd_n = 1'b0;
        chk(SigWait, 8'd1, "mem idle");
        tick(); chk(SigWait, 8'd0, "mem t1");
        tick(); chk(SigWait, 8'd0, "mem t2");
        tick(); chk(SigWait, 8'd1, "mem t3 done");
        mreq_n = 1'b1; rd_n = 1'b1;
        tick(); chk(SigWait, 8'd1, "mem end");

        // I/O write, IO_WAIT=1, then slave not ready for five more T-states.
        iorq_n = 1'b0; wr_n = 1'b0; ext_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(); chk(SigWait, 8'd0, $sformatf("io low t%0d", i));
        end
        ext_rdy = 1'b1;
        chk(SigWait, 8'd0, "io ready pending");
        tick(); chk(SigWait, 8'd1, "io done");
        iorq_n = 1'b1; wr_n = 1'b1;
        tick(); chk(SigWait, 8'd1, "io end");

        // Refresh is never waited.
        mreq_n = 1'b0; rfsh_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(); chk(SigWait, 8'd1, $sformatf("refresh t%0d", i));
        end
        mreq_n = 1'b1; rfsh_n = 1'b1;
        tick();

        // Strobes vanish mid-count: WAIT_n releases at the next T-state.
        mreq_n = 1'b0; rd_n = 1'b0;
        tick(); chk(SigWait, 8'd0, "lost count");
        mreq_n = 1'b1; rd_n = 1'b1;
        chk(SigWait, 8'd0, "lost before tick");
        tick(); chk(SigWait, 8'd1, "lost released");

        // INT without acknowledge: 32 T-states low; a second edge mid-pulse is ignored.
        pulse_int();
        chk(SigInt, 8'd0, "int asserted");
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (i == 5) pulse_int();
            chk(SigInt, 8'd0, $sformatf("int low t%0d", i));
        end
        tick(); chk(SigInt, 8'd1, "int timeout t32");
        tick(); chk(SigInt, 8'd1, "int stays high");

        // INT acknowledged by an inta cycle at the tenth T-state.
        pulse_int();
        for (int i = 1; i <= 9; i++) begin
            tick(); chk(SigInt, 8'd0, $sformatf("int2 low t%0d", i));
        end
        m1_n = 1'b0; iorq_n = 1'b0;
        chk(SigInt, 8'd0, "int pre inta");
        chk(SigVecOe, InTaOe, "vec_oe during inta");
        chk(SigVecDo, 8'hFF, "vec_do during inta");
        tick();
        chk(SigInt, 8'd1, "int inta release t10");
        chk(SigWait, 8'd1, "inta no wait");
        m1_n = 1'b1; iorq_n = 1'b1;
        tick(); chk(SigInt, 8'd1, "int after inta");

        // NMI: two edges two T-states apart give one 4 T-state pulse.
        pulse_nmi();
        chk(SigNmi, 8'd0, "nmi asserted");
        tick(); chk(SigNmi, 8'd0, "nmi t1");
        tick(); chk(SigNmi, 8'd0, "nmi t2");
        pulse_nmi();
        tick(); chk(SigNmi, 8'd0, "nmi t3");
        tick(); chk(SigNmi, 8'd1, "nmi t4 end");
        tick(); chk(SigNmi, 8'd1, "nmi no retrigger a");
        tick(); chk(SigNmi, 8'd1, "nmi no retrigger b");

        // Arbiter: both request, channel 0 first, channel 1 on the next episode.
        dma_req = 2'b11;
        idle(1);
        chk(SigBusrq, 8'd0, "arb req busrq");
        chk(SigGnt,   8'd0, "arb no gnt before busak");
        idle(2);
        chk(SigGnt,   8'd0, "arb still no gnt");
        busak_n = 1'b0;
        idle(1);
        chk(SigGnt,   8'd1, "arb gnt 01");
        chk(SigBusrq, 8'd0, "arb gnt busrq");
        dma_req = 2'b10;
        idle(1);
        chk(SigGnt,   8'd0, "arb release gnt");
        chk(SigBusrq, 8'd1, "arb release busrq");
        idle(2);
        chk(SigBusrq, 8'd1, "arb rel holds");
        chk(SigGnt,   8'd0, "arb one grant per episode");
        busak_n = 1'b1;
        idle(2);
        chk(SigBusrq, 8'd0, "arb episode2 req");
        busak_n = 1'b0;
        idle(1);
        chk(SigGnt,   8'd2, "arb gnt 10");
        dma_req = 2'b00;
        idle(1);
        chk(SigBusrq, 8'd1, "arb episode2 release");
        chk(SigGnt,   8'd0, "arb episode2 gnt off");
        busak_n = 1'b1;
        idle(1);

        // All requests withdrawn before BUSAK.
        dma_req = 2'b01;
        idle(1);
        chk(SigBusrq, 8'd0, "arb req3 busrq");
        dma_req = 2'b00;
        idle(1);
        chk(SigBusrq, 8'd1, "arb req drop busrq");
        idle(1);
        chk(SigBusrq, 8'd1, "arb idle again");

        // Asynchronous reset in the middle of a wait count.
        mreq_n = 1'b0; rd_n = 1'b0;
        tick();
        chk(SigWait, 8'd0, "pre-reset count");
        settle();
        rst_n = 1'b0;
        #1;
        if (wait_n !== 1'b1 || busrq_n !== 1'b1 || dma_gnt !== '0) begin
            errors++;
            $display("FAIL rst mid-count immediate: wait=%b busrq=%b gnt=%b",
                     wait_n, busrq_n, dma_gnt);
        end
        chk_reset_outputs("rst mid-count");
        @(negedge clk);
        #1;
        mreq_n = 1'b1; rd_n = 1'b1; rst_n = 1'b1;
        idle(1);

        // Asynchronous reset while a DMA grant, INT and NMI are all active.
        pulse_int();
        pulse_nmi();
        dma_req = 2'b01;
        idle(1);
        busak_n = 1'b0;
        idle(1);
        chk(SigGnt, 8'd1, "pre-reset gnt");
        chk(SigInt, 8'd0, "pre-reset int");
        chk(SigNmi, 8'd0, "pre-reset nmi");
        settle();
        rst_n = 1'b0;
        #1;
        if (dma_gnt !== '0 || int_n !== 1'b1 || nmi_n !== 1'b1 || busrq_n !== 1'b1) begin
            errors++;
            $display("FAIL rst mid-gnt immediate: gnt=%b int=%b nmi=%b busrq=%b",
                     dma_gnt, int_n, nmi_n, busrq_n);
        end
        chk_reset_outputs("rst mid-gnt");
        @(negedge clk);
        #1;
        dma_req = '0; busak_n = 1'b1; rst_n = 1'b1;
        idle(2);
        chk(SigBusrq, 8'd1, "post-reset busrq");
        chk(SigInt,   8'd1, "post-reset int");

        @(negedge clk);
        #1;
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks executed: %0d", checks);
        end
        if (errors != 0) begin
            $display("FAIL Result: errors=%0d of %0d checks", errors, checks);
        end else begin
            $display("PASS Result: errors=%0d of %0d checks", errors, checks);
        end
        $finish;
    end

endmodule
